calc_sequencer: RTL

Parametrised calculator front-end that replaces the four-button load scheme (separate load strobes for A, B, opcode and result) with a two-button sequenced entry flow. It synchronises and edge-detects an ENTER and an UNDO button, steps a 4-state FSM through operand/opcode capture, and computes a registered N-bit ALU result with 5 flags. It supports accumulator chaining and step-back, and drives a single display word for the downstream hex/seven-segment driver.

---
 rtl/calc_pkg.sv | 35 +++
 rtl/btn_edge.sv | 32 +++
 rtl/calc_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_pkg;

  // Entry-flow states, in the order the user walks through them.
  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  // Opcode encoding matches the op_in switch positions.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_OR  = 2'd2,
    OP_AND = 2'd3
  } opcode_t;

  // Bit positions inside the 5-bit flags word.
  localparam int FLG_N = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_P = 0;

  // One-hot LED pattern shown for each state.
  function automatic logic [3:0] state_onehot(input state_t s);
    logic [3:0] leds;
    leds = 4'b0000;
    leds[s] = 1'b1;
    return leds;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for one asynchronous button.
// All flops come up set, so a button already held when reset releases looks
// "old" and never produces a pulse until it is released and pressed again.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronise the button and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift as a real
      // chain; blocking ones would collapse them into a single stage.
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/calc_sequencer.sv
// Two-button sequenced calculator front-end: ENTER steps through A, B and
// opcode capture, UNDO steps back, SHOW displays a registered ALU result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic [N-1:0] data_in,
  input  logic [1:0]   op_in,
  input  logic         btn_enter,
  input  logic         btn_undo,
  output logic [N-1:0] display_value,
  output logic [3:0]   state_leds,
  output logic [4:0]   flags,
  output logic         result_valid
);

  logic         w_enter_p;
  logic         w_undo_p;
  logic [N-1:0] w_alu_result;
  logic [4:0]   w_alu_flags;

  state_t       r_state;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_result;
  logic [4:0]   r_flags;
  logic [3:0]   r_state_leds;
  logic         r_result_valid;

  btn_edge u_enter (
    .clk     (CLK100MHZ),
    .rst_n   (CPU_RESETN),
    .i_btn   (btn_enter),
    .o_pulse (w_enter_p)
  );

  btn_edge u_undo (
    .clk     (CLK100MHZ),
    .rst_n   (CPU_RESETN),
    .i_btn   (btn_undo),
    .o_pulse (w_undo_p)
  );

  // ALU: result and flags from the captured operands and the live opcode.
  always_comb begin
    logic [N:0] w_sum;
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_sum        = '0;
    w_alu_result = '0;
    w_alu_flags  = '0;
    unique case (opcode_t'(op_in))
      OP_ADD: begin
        w_sum        = {1'b0, r_a} + {1'b0, r_b};
        w_alu_result = w_sum[N-1:0];
        w_alu_flags[FLG_C] = w_sum[N];
        w_alu_flags[FLG_V] = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
      end
      OP_SUB: begin
        w_sum        = {1'b0, r_a} + {1'b0, ~r_b} + {{N{1'b0}}, 1'b1};
        w_alu_result = w_sum[N-1:0];
        w_alu_flags[FLG_C] = w_sum[N];
        w_alu_flags[FLG_V] = (r_a[N-1] != r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
      end
      OP_OR:   w_alu_result = r_a | r_b;
      OP_AND:  w_alu_result = r_a & r_b;
      default: w_alu_result = '0;
    endcase
    w_alu_flags[FLG_N] = w_alu_result[N-1];
    w_alu_flags[FLG_Z] = (w_alu_result == '0);
    w_alu_flags[FLG_P] = ^w_alu_result;
  end

  // Entry FSM with operand/result registers and registered status outputs.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      // NOTE: these are plain registers, not a memory, so every one of them
      // is reset to give a defined state after an abort mid-sequence.
      r_state        <= WAIT_A;
      r_a            <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_flags        <= '0;
      r_state_leds   <= state_onehot(WAIT_A);
      r_result_valid <= 1'b0;
    end else if (w_enter_p && !w_undo_p) begin
      unique case (r_state)
        WAIT_A: begin
          r_a          <= data_in;
          r_state      <= WAIT_B;
          r_state_leds <= state_onehot(WAIT_B);
        end
        WAIT_B: begin
          r_b          <= data_in;
          r_state      <= WAIT_OP;
          r_state_leds <= state_onehot(WAIT_OP);
        end
        WAIT_OP: begin
          r_result       <= w_alu_result;
          r_flags        <= w_alu_flags;
          r_state        <= SHOW;
          r_state_leds   <= state_onehot(SHOW);
          r_result_valid <= 1'b1;
        end
        SHOW: begin
          // Chain: the shown result becomes the next A operand.
          r_a            <= r_result;
          r_state        <= WAIT_B;
          r_state_leds   <= state_onehot(WAIT_B);
          r_result_valid <= 1'b0;
        end
        default: begin
          r_state      <= WAIT_A;
          r_state_leds <= state_onehot(WAIT_A);
        end
      endcase
    end else if (w_undo_p && !w_enter_p) begin
      unique case (r_state)
        WAIT_A: r_a <= '0;
        WAIT_B: begin
          r_state      <= WAIT_A;
          r_state_leds <= state_onehot(WAIT_A);
        end
        WAIT_OP: begin
          r_state      <= WAIT_B;
          r_state_leds <= state_onehot(WAIT_B);
        end
        SHOW: begin
          // Result and flags hold so re-entering SHOW can recompute cleanly.
          r_state        <= WAIT_OP;
          r_state_leds   <= state_onehot(WAIT_OP);
          r_result_valid <= 1'b0;
        end
        default: begin
          r_state      <= WAIT_A;
          r_state_leds <= state_onehot(WAIT_A);
        end
      endcase
    end
  end

  // Display word: live switches while entering operands, opcode, then result.
  always_comb begin
    display_value = data_in;
    unique case (r_state)
      WAIT_OP: display_value = {{(N-2){1'b0}}, op_in};
      SHOW:    display_value = r_result;
      default: display_value = data_in;
    endcase
  end

  assign state_leds   = r_state_leds;
  assign flags        = r_flags;
  assign result_valid = r_result_valid;

endmodule
